nx1_wb_bridge: RTL and testbench

Wishbone classic slave front-end that feeds the NEUROMORPHIC_X1 32x32 macro's functional port. It decodes the bus address window and latches one request. It drives EN/R_WB/DI/AD/SEL to the macro, holds them until func_ack, captures read data and completes the bus cycle. Only one request is outstanding at a time; an optional watchdog turns a hung macro access into a bus error.

---
 rtl/nx1_wb_bridge.sv | 164 ++++++++++++++++
 tb/tb_nx1_wb_bridge.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nx1_wb_bridge.sv
// nx1_wb_bridge: Wishbone classic slave front-end for the NEUROMORPHIC_X1 functional port.
// Decodes an address window, latches one request, drives EN/R_WB/DI/AD/SEL until func_ack,
// captures read data and completes the bus cycle. One request outstanding at a time.
// Optional feature macro: NX1_WB_TIMEOUT_EN (watchdog turns a hung access into wbs_err_o).
// Ports:
//   CLKin, RSTin           clock, async active-low reset
//   wbs_cyc_i/stb_i/we_i   bus cycle, strobe, write enable
//   wbs_sel_i/adr_i/dat_i  byte select, address, write data
//   wbs_ack_o/err_o        one-cycle completion / error pulses
//   wbs_dat_o              read data (holds last read value)
//   mac_en/r_wb/di/ad/sel  request fields to the macro
//   mac_do, mac_ack        read data and func_ack from the macro
//   busy_o                 high whenever the bridge is not idle
module nx1_wb_bridge #(
    parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
    parameter logic [31:0] ADDR_MASK      = 32'hFFFF_0000,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        CLKin,
    input  logic        RSTin,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic        wbs_err_o,
    output logic [31:0] wbs_dat_o,
    output logic        mac_en,
    output logic        mac_r_wb,
    output logic [31:0] mac_di,
    output logic [31:0] mac_ad,
    output logic [3:0]  mac_sel,
    input  logic [31:0] mac_do,
    input  logic        mac_ack,
    output logic        busy_o
);

    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_t;

    state_t      state, state_nxt;
    logic        cycstb_c, hit_c, timeout_c;
    logic        aborted, aborted_nxt;
    logic        ack_nxt, err_nxt, en_nxt, r_wb_nxt, busy_nxt;
    logic [31:0] dat_nxt, di_nxt, ad_nxt;
    logic [3:0]  sel_nxt;

    assign cycstb_c = wbs_cyc_i & wbs_stb_i;
    assign hit_c    = cycstb_c & ((wbs_adr_i & ADDR_MASK) == BASE_ADDR);

`ifdef NX1_WB_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wdog;

    // Watchdog: cleared on entry to REQ, counts REQ cycles without func_ack.
    always_ff @(posedge CLKin or negedge RSTin) begin
        if (!RSTin) begin
            wdog <= '0;
        end else if (state == S_IDLE && hit_c) begin
            wdog <= '0;
        end else if (state == S_REQ && !mac_ack) begin
            wdog <= wdog + CNT_W'(1);
        end
    end

    // An ack in the limit cycle takes priority over the timeout.
    assign timeout_c = (state == S_REQ) && !mac_ack && (wdog == WDOG_LAST);
`else
    logic unused_timeout;
    assign unused_timeout = |32'(TIMEOUT_CYCLES);
    assign timeout_c      = 1'b0;
`endif

    // State and output registers.
    always_ff @(posedge CLKin or negedge RSTin) begin
        if (!RSTin) begin
            state     <= S_IDLE;
            aborted   <= 1'b0;
            wbs_ack_o <= 1'b0;
            wbs_err_o <= 1'b0;
            wbs_dat_o <= '0;
            mac_en    <= 1'b0;
            mac_r_wb  <= 1'b0;
            mac_di    <= '0;
            mac_ad    <= '0;
            mac_sel   <= '0;
            busy_o    <= 1'b0;
        end else begin
            state     <= state_nxt;
            aborted   <= aborted_nxt;
            wbs_ack_o <= ack_nxt;
            wbs_err_o <= err_nxt;
            wbs_dat_o <= dat_nxt;
            mac_en    <= en_nxt;
            mac_r_wb  <= r_wb_nxt;
            mac_di    <= di_nxt;
            mac_ad    <= ad_nxt;
            mac_sel   <= sel_nxt;
            busy_o    <= busy_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt   = state;
        aborted_nxt = aborted;
        ack_nxt     = 1'b0;
        err_nxt     = 1'b0;
        dat_nxt     = wbs_dat_o;
        en_nxt      = mac_en;
        r_wb_nxt    = mac_r_wb;
        di_nxt      = mac_di;
        ad_nxt      = mac_ad;
        sel_nxt     = mac_sel;

        case (state)
            S_IDLE: begin
                if (hit_c) begin
                    r_wb_nxt    = ~wbs_we_i;
                    di_nxt      = wbs_dat_i;
                    ad_nxt      = wbs_adr_i & ~ADDR_MASK;
                    sel_nxt     = wbs_sel_i;
                    en_nxt      = 1'b1;
                    aborted_nxt = 1'b0;
                    state_nxt   = S_REQ;
                end
            end
            S_REQ: begin
                // The macro access cannot be cancelled; a dropped cycle only suppresses the response.
                if (!cycstb_c) begin
                    aborted_nxt = 1'b1;
                end
                if (mac_ack || timeout_c) begin
                    en_nxt = 1'b0;
                    if (mac_r_wb) begin
                        dat_nxt = mac_ack ? mac_do : TIMEOUT_DATA;
                    end
                    // Response is registered here so it appears in the RESP cycle.
                    ack_nxt   = mac_ack && cycstb_c && !aborted;
                    err_nxt   = !mac_ack && cycstb_c && !aborted;
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                // A responded cycle takes the dead DONE cycle so its still-high stb cannot re-hit.
                state_nxt = (wbs_ack_o || wbs_err_o) ? S_DONE : S_IDLE;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        busy_nxt = (state_nxt != S_IDLE);
    end

endmodule

// File: tb/tb_nx1_wb_bridge.sv
// tb_nx1_wb_bridge: directed bench for nx1_wb_bridge with a transaction-level timeline model.
// Each transaction records when EN must start, how long it lasts, and how it ends; a compare
// process derives every expected output per cycle from that record.
module tb_nx1_wb_bridge;

    localparam logic [31:0] ADDR_MASK = 32'hFFFF_0000;
    localparam int          TO_CYC    = 8;

    logic        CLKin, RSTin;
    logic        wb_cyc, wb_stb, wb_we;
    logic [3:0]  wb_sel;
    logic [31:0] wb_adr, wb_dat;
    logic        wbs_ack_o, wbs_err_o, mac_en, mac_r_wb, busy_o;
    logic [31:0] wbs_dat_o, mac_di, mac_ad, mac_do;
    logic [3:0]  mac_sel;
    logic        mac_ack;

    nx1_wb_bridge #(.TIMEOUT_CYCLES(TO_CYC)) dut (
        .CLKin(CLKin), .RSTin(RSTin),
        .wbs_cyc_i(wb_cyc), .wbs_stb_i(wb_stb), .wbs_we_i(wb_we),
        .wbs_sel_i(wb_sel), .wbs_adr_i(wb_adr), .wbs_dat_i(wb_dat),
        .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o), .wbs_dat_o(wbs_dat_o),
        .mac_en(mac_en), .mac_r_wb(mac_r_wb), .mac_di(mac_di), .mac_ad(mac_ad),
        .mac_sel(mac_sel), .mac_do(mac_do), .mac_ack(mac_ack), .busy_o(busy_o)
    );

    initial CLKin = 1'b0;
    always #5 CLKin = ~CLKin;

    int cyc_n = 0;
    always @(posedge CLKin) cyc_n <= cyc_n + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    // Transaction record (the model).
    bit          chk_on = 1'b0;
    bit          t_valid = 1'b0;
    int          t_k = 0, t_n = 0;
    bit          t_we, t_abort, t_err;
    logic [31:0] t_ad, t_di, t_rdata;
    logic [3:0]  t_sel;
    logic [31:0] last_rd = 32'h0;

    // Observations collected for the literal checks.
    int          en_cnt, ack_cnt, err_cnt, ack_cyc, drive_cyc;
    logic [31:0] cap_ad, cap_di;
    logic        cap_rwb;

    int          cd;
    bit          e_en, e_ack, e_err, e_busy;
    logic [31:0] e_dat;

    // Per-cycle compare, sampled 1 time unit after the active edge.
    always @(posedge CLKin) begin
        #1;
        if (chk_on) begin
            cd     = cyc_n - t_k;
            e_en   = t_valid && cd >= 0 && cd < t_n;
            e_ack  = t_valid && cd == t_n && !t_abort && !t_err;
            e_err  = t_valid && cd == t_n && !t_abort && t_err;
            e_busy = t_valid && cd >= 0 && cd <= t_n + (t_abort ? 0 : 1);
            e_dat  = (t_valid && !t_we && cd >= t_n) ? t_rdata : last_rd;
            chk("mac_en",    32'(mac_en),    32'(e_en));
            chk("wbs_ack_o", 32'(wbs_ack_o), 32'(e_ack));
            chk("wbs_err_o", 32'(wbs_err_o), 32'(e_err));
            chk("busy_o",    32'(busy_o),    32'(e_busy));
            chk("wbs_dat_o", wbs_dat_o,      e_dat);
            if (e_en) begin
                chk("mac_r_wb", 32'(mac_r_wb), 32'(!t_we));
                chk("mac_ad",   mac_ad,        t_ad);
                chk("mac_di",   mac_di,        t_di);
                chk("mac_sel",  32'(mac_sel),  32'(t_sel));
            end
            if (mac_en) begin
                en_cnt++;
                cap_ad  = mac_ad;
                cap_di  = mac_di;
                cap_rwb = mac_r_wb;
            end
            if (wbs_ack_o) begin
                ack_cnt++;
                ack_cyc = cyc_n;
            end
            if (wbs_err_o) err_cnt++;
        end
    end

    task automatic clear_obs();
        en_cnt = 0; ack_cnt = 0; err_cnt = 0; ack_cyc = -1;
    endtask

    // One bus access; the macro acks in the n-th EN cycle unless to=1 (never acks).
    // abort drops cyc/stb in the first EN cycle; hold keeps stb high through the DONE cycle.
    task automatic txn(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                       input logic [3:0] sel, input int n, input logic [31:0] rdata,
                       input bit abort, input bit to, input bit hold);
        int d;
        drive_cyc = cyc_n;
        t_k = cyc_n + 1; t_n = n; t_we = we; t_abort = abort; t_err = to;
        t_ad = adr & ~ADDR_MASK; t_di = wdat; t_sel = sel;
        t_rdata = to ? 32'hDEAD_BEEF : rdata;
        clear_obs();
        t_valid = 1'b1;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_dat = wdat; wb_sel = sel;
        for (int i = 0; i <= n + 2; i++) begin
            @(negedge CLKin);
            d = cyc_n - t_k;
            mac_ack = !to && (d == n - 1);
            mac_do  = (d == n - 1) ? rdata : $urandom;
            if ((abort && d == 0) || (d == n + (hold ? 2 : 0))) begin
                wb_cyc = 1'b0; wb_stb = 1'b0;
            end
        end
        t_valid = 1'b0;
        mac_ack = 1'b0;
        if (!we) last_rd = t_rdata;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ack"},  32'(wbs_ack_o), 32'h0);
        chk({tag, "_err"},  32'(wbs_err_o), 32'h0);
        chk({tag, "_dat"},  wbs_dat_o,      32'h0);
        chk({tag, "_en"},   32'(mac_en),    32'h0);
        chk({tag, "_rwb"},  32'(mac_r_wb),  32'h0);
        chk({tag, "_di"},   mac_di,         32'h0);
        chk({tag, "_ad"},   mac_ad,         32'h0);
        chk({tag, "_sel"},  32'(mac_sel),   32'h0);
        chk({tag, "_busy"}, 32'(busy_o),    32'h0);
    endtask

    initial begin
        wb_cyc = 0; wb_stb = 0; wb_we = 0; wb_sel = 0; wb_adr = 0; wb_dat = 0;
        mac_do = 0; mac_ack = 0;
        RSTin = 1'b1;
        clear_obs();
        #1 RSTin = 1'b0;
        #2 chk_all_zero("reset");
        repeat (2) @(negedge CLKin);
        RSTin = 1'b1;
        chk_on = 1'b1;
        @(negedge CLKin);

        // Write hit, ack in the 3rd EN cycle.
        txn(1'b1, 32'h3000_0010, 32'hA5A5_0001, 4'hF, 3, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("wr_en_cycles", 32'(en_cnt), 32'd3);
        chk("wr_ack_count", 32'(ack_cnt), 32'd1);
        chk("wr_ad",  cap_ad, 32'h0000_0010);
        chk("wr_di",  cap_di, 32'hA5A5_0001);
        chk("wr_rwb", 32'(cap_rwb), 32'h0);
        chk("wr_busy_after", 32'(busy_o), 32'h0);

        // Read hit with immediate ack: ack two cycles after the hit cycle.
        txn(1'b0, 32'h3000_0004, 32'h0, 4'hF, 1, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
        chk("rd_latency", 32'(ack_cyc - drive_cyc), 32'd2);
        chk("rd_data", wbs_dat_o, 32'h1234_5678);
        chk("rd_rwb", 32'(cap_rwb), 32'h1);

        // Back-to-back read with stb held through DONE: must not re-trigger.
        txn(1'b0, 32'h3000_0008, 32'h0, 4'h3, 1, 32'h0BAD_F00D, 1'b0, 1'b0, 1'b1);
        chk("b2b_ack_count", 32'(ack_cnt), 32'd1);

        // Write with sel=0 at the top of the window; read data must be held.
        txn(1'b1, 32'h3000_FFFC, 32'h5555_AAAA, 4'h0, 2, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("sel0_dat_held", wbs_dat_o, 32'h0BAD_F00D);

        // Address miss held 20 cycles, with stray func_ack pulses while idle.
        clear_obs();
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 32'h4000_0000;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLKin);
            mac_ack = (i % 3 == 1);
            mac_do  = $urandom;
        end
        wb_cyc = 1'b0; wb_stb = 1'b0; mac_ack = 1'b0;
        @(negedge CLKin);
        chk("miss_en_cycles", 32'(en_cnt), 32'd0);
        chk("miss_ack_err", 32'(ack_cnt + err_cnt), 32'd0);

        // Master abort during REQ: EN runs to the late ack, no bus response.
        txn(1'b0, 32'h3000_0020, 32'h0, 4'hF, 6, 32'hCAFE_0001, 1'b1, 1'b0, 1'b0);
        chk("abort_en_cycles", 32'(en_cnt), 32'd6);
        chk("abort_ack_count", 32'(ack_cnt), 32'd0);

        // Next hit after the abort is accepted.
        txn(1'b1, 32'h3000_0030, 32'h0000_0077, 4'h1, 2, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("post_abort_ack", 32'(ack_cnt), 32'd1);

`ifdef NX1_WB_TIMEOUT_EN
        // Hung read: EN for TO_CYC cycles, then an error with the poison value.
        txn(1'b0, 32'h3000_0040, 32'h0, 4'hF, TO_CYC, 32'h0, 1'b0, 1'b1, 1'b0);
        chk("to_en_cycles", 32'(en_cnt), 32'd8);
        chk("to_err_count", 32'(err_cnt), 32'd1);
        chk("to_ack_count", 32'(ack_cnt), 32'd0);
        chk("to_data", wbs_dat_o, 32'hDEAD_BEEF);
        // Ack in the very last allowed cycle wins over the timeout.
        txn(1'b0, 32'h3000_0044, 32'h0, 4'hF, TO_CYC, 32'h0000_8888, 1'b0, 1'b0, 1'b0);
        chk("edge_ack_count", 32'(ack_cnt), 32'd1);
        chk("edge_err_count", 32'(err_cnt), 32'd0);
`else
        // Without the watchdog a slow macro simply takes longer.
        txn(1'b0, 32'h3000_0040, 32'h0, 4'hF, 12, 32'h0000_8888, 1'b0, 1'b0, 1'b0);
        chk("slow_ack_count", 32'(ack_cnt), 32'd1);
        chk("slow_err_count", 32'(err_cnt), 32'd0);
`endif

        // Reset asserted mid-REQ: everything drops asynchronously, no response afterwards.
        t_k = cyc_n + 1; t_n = 5; t_we = 1'b0; t_abort = 1'b0; t_err = 1'b0;
        t_ad = 32'h0000_0050; t_di = 32'h0; t_sel = 4'hF; t_rdata = 32'h0;
        t_valid = 1'b1;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 32'h3000_0050; wb_dat = 0; wb_sel = 4'hF;
        repeat (2) @(negedge CLKin);
        chk("pre_reset_en", 32'(mac_en), 32'h1);
        #2 RSTin = 1'b0;
        chk_on = 1'b0;
        #1 chk_all_zero("midreset");
        t_valid = 1'b0; last_rd = 32'h0;
        wb_cyc = 1'b0; wb_stb = 1'b0;
        @(negedge CLKin);
        RSTin = 1'b1;
        clear_obs();
        chk_on = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLKin);
            mac_ack = (i % 2 == 0);
        end
        mac_ack = 1'b0;
        chk("post_reset_ack", 32'(ack_cnt + err_cnt), 32'd0);

        // Normal read after reset.
        txn(1'b0, 32'h3000_0060, 32'h0, 4'hF, 2, 32'h6060_6060, 1'b0, 1'b0, 1'b0);
        chk("final_rd_data", wbs_dat_o, 32'h6060_6060);

        chk_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
